multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Control FSM for the 8-bit multicycle processor datapath.
- Consumes the opcode fields (Op, Funct) and ALU flags from the datapath; drives every datapath control input.
- Holds the architectural NZCV flag register. Each instruction takes 3 cycles: FETCH, DECODE, EXEC.
- Instruction fields: Op=Inst[15:14], Funct=Inst[13:11], Rd=[10:8], Rm=[7:5], Rn=[4:2], imm8=[7:0].

Parameters:
ALU_ADD, 3'b000, ALUControl code for addition
ALU_SUB, 3'b001, ALUControl code for subtraction (used by CMP)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Op  input  2  instruction class from instruction register
Funct  input  3  instruction sub-function
Flags  input  4  live ALU flags {N,Z,C,V}
PCWrite, AdrSrc, MemWrite, IRWrite, WriteASrc, ALUSrcA, ALUSrcB, RegWrite, RegSrc  output  1 each  datapath controls
WriteDSrc  output  2  register write-data select (0 Result, 1 PC, 2 memory)
ALUControl  output  3  ALU operation
ShiftType  output  3  shifter operation (000 = pass-through)
ResultSrc  output  2  Result select (0 ALU, 1 shifter, 2 imm8)
FlagsReg  output  4  registered {N,Z,C,V}
Halted  output  1  core halted (optional feature)

Behaviour:
- States: RST, FETCH, DECODE, EXEC, HALT.
  - Async Reset forces RST and clears FlagsReg to 0. In RST all outputs are 0.
  - Transitions: RST->FETCH->DECODE->EXEC->FETCH, each unconditional on the next edge.
- Outputs are combinational from state, Op, Funct and FlagsReg. Any output not listed for a state is 0.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=1, ALUControl=ALU_ADD, ResultSrc=0, PCWrite=1. This loads IR and sets PC<=PC+2.
- DECODE: operand registers capture. RegSrc=1 iff the instruction is STR, so the store data is Rd.
- EXEC, Op=00 (data processing):
  - Funct 000-110: ALUSrcA=0, ALUSrcB=0, ShiftType=000, ALUControl=Funct, ResultSrc=0, WriteDSrc=0, RegWrite=1.
  - Funct 111 (CMP): same controls but ALUControl=ALU_SUB and RegWrite=0.
  - FlagsReg<=Flags at end of EXEC for every Op=00 instruction.
- EXEC, Op=01 (memory, absolute imm8 address): AdrSrc=1, ResultSrc=2.
  - Funct[0]=0 (LDR): WriteDSrc=2, RegWrite=1.
  - Funct[0]=1 (STR): RegSrc=1, MemWrite=1.
- EXEC, Op=10 (branch to imm8): condition taken from Funct.
  - 000 AL, 001 EQ(Z), 010 NE(!Z), 011 CS(C), 100 MI(N), 101 VS(V), 110 BL(always), 111 LT(N^V).
  - Taken: ResultSrc=2, PCWrite=1.
  - BL additionally: RegWrite=1, WriteASrc=1, WriteDSrc=1. R7 receives the pre-update PC (return address) on the same edge.
  - Conditions evaluate FlagsReg, never live Flags.
- EXEC, Op=11:
  - Funct 111 (MOVI): ResultSrc=2, RegWrite=1.
  - Otherwise (shift): ShiftType=Funct, ResultSrc=1, RegWrite=1, WriteDSrc=0.
- FlagsReg updates only in EXEC of Op=00.
- Reset asserted mid-instruction aborts it. No write strobe may be asserted while Reset=1.

Optional Feature:
- Macro CTRL_HALT_EN.
- Defined: Op=01, Funct=111 in DECODE transitions to HALT instead of EXEC, with no memory write.
  - HALT asserts Halted=1, all other outputs 0, and is left only by Reset.
- Undefined: the HALT state is absent, Halted is tied 0, and Op=01/Funct=111 executes as STR.

Test Plan:
- Release Reset; memory word0 = 0x0000 (ADD R0,R0,R0) -> RST one cycle with all outputs 0; then IRWrite=PCWrite=1 in FETCH; PC=2 after FETCH; RegWrite=1 in EXEC.
- R1=0x05, R2=0x05, CMP (Op00 Funct111), then BEQ 0x40 -> CMP has RegWrite=0 and sets FlagsReg Z=1; branch EXEC has PCWrite=1, ResultSrc=2, PC=0x40.
- BL 0x20 fetched at PC=0x10 -> EXEC shows WriteASrc=1, WriteDSrc=1, PCWrite=1; R7=0x12, PC=0x20.
- STR R3,[0x30] with R3=0xAB -> RegSrc=1 in DECODE and EXEC; MemWrite=1 for exactly one cycle; mem[0x30][7:0]=0xAB. LDR R4,[0x30] -> R4=0xAB.
- Assert Reset during DECODE of an ADD -> state RST, FlagsReg=0, no RegWrite; refetch from PC=0.
- With CTRL_HALT_EN, word 0x7800 -> Halted=1 from the cycle after DECODE; PC stays frozen for 20 cycles; MemWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Control FSM for the 8-bit multicycle datapath: FETCH/DECODE/EXEC sequencing plus the NZCV
// register. Define CTRL_HALT_EN to decode Op=01/Funct=111 as HALT instead of STR.
module multicycle_control_unit #(
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_op,
    input  logic [2:0] i_funct,
    input  logic [3:0] i_flags,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_write_a_src,
    output logic       o_alu_src_a,
    output logic       o_alu_src_b,
    output logic       o_reg_write,
    output logic       o_reg_src,
    output logic [1:0] o_write_d_src,
    output logic [2:0] o_alu_control,
    output logic [2:0] o_shift_type,
    output logic [1:0] o_result_src,
    output logic [3:0] o_flags_reg,
    output logic       o_halted
);

    typedef enum logic [2:0] {
        StRst    = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
`ifdef CTRL_HALT_EN
        StHalt   = 3'd4,
`endif
        StExec   = 3'd3
    } state_e;

    state_e     r_state;
    logic [3:0] r_flags;
    logic       w_is_str;
    logic       w_taken;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

`ifdef CTRL_HALT_EN
    logic w_is_halt;
    assign w_is_halt = (i_op == 2'b01) && (i_funct == 3'b111);
    assign w_is_str  = (i_op == 2'b01) && i_funct[0] && !w_is_halt;
`else
    assign w_is_str  = (i_op == 2'b01) && i_funct[0];
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StRst;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                StRst:    r_state <= StFetch;
                StFetch:  r_state <= StDecode;
                StDecode: begin
                    r_state <= StExec;
`ifdef CTRL_HALT_EN
                    if (w_is_halt) r_state <= StHalt;
`endif
                end
                StExec: begin
                    r_state <= StFetch;
                    if (i_op == 2'b00) r_flags <= i_flags;
                end
`ifdef CTRL_HALT_EN
                StHalt:   r_state <= StHalt;
`endif
                default:  r_state <= StRst;
            endcase
        end
    end

    // Branch conditions read the architectural flags, never the live ALU flags.
    always_comb begin
        w_taken = 1'b0;
        case (i_funct)
            3'b000:  w_taken = 1'b1;
            3'b001:  w_taken = r_flags[2];
            3'b010:  w_taken = !r_flags[2];
            3'b011:  w_taken = r_flags[1];
            3'b100:  w_taken = r_flags[3];
            3'b101:  w_taken = r_flags[0];
            3'b110:  w_taken = 1'b1;
            default: w_taken = r_flags[3] ^ r_flags[0];
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b0;
        o_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        o_write_a_src = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 1'b0;
        w_reg_write   = 1'b0;
        o_reg_src     = 1'b0;
        o_write_d_src = 2'd0;
        o_alu_control = ALU_ADD;
        o_shift_type  = 3'b000;
        o_result_src  = 2'd0;
        o_halted      = 1'b0;
        case (r_state)
            StFetch: begin
                w_ir_write    = 1'b1;
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 1'b1;
                o_alu_control = ALU_ADD;
                w_pc_write    = 1'b1;
            end
            StDecode: o_reg_src = w_is_str;
            StExec: begin
                case (i_op)
                    2'b00: begin
                        o_alu_control = (i_funct == 3'b111) ? ALU_SUB : i_funct;
                        w_reg_write   = (i_funct != 3'b111);
                    end
                    2'b01: begin
                        o_adr_src    = 1'b1;
                        o_result_src = 2'd2;
                        if (w_is_str) begin
                            o_reg_src   = 1'b1;
                            w_mem_write = 1'b1;
                        end else begin
                            o_write_d_src = 2'd2;
                            w_reg_write   = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (w_taken) begin
                            o_result_src = 2'd2;
                            w_pc_write   = 1'b1;
                        end
                        // BL: R7 takes the pre-update PC as the return address.
                        if (i_funct == 3'b110) begin
                            w_reg_write   = 1'b1;
                            o_write_a_src = 1'b1;
                            o_write_d_src = 2'd1;
                        end
                    end
                    default: begin
                        w_reg_write = 1'b1;
                        if (i_funct == 3'b111) begin
                            o_result_src = 2'd2;
                        end else begin
                            o_shift_type = i_funct;
                            o_result_src = 2'd1;
                        end
                    end
                endcase
            end
`ifdef CTRL_HALT_EN
            StHalt: o_halted = 1'b1;
`endif
            default: ;
        endcase
    end

    // Strobes are masked directly by Reset so no write can slip out during assertion.
    assign o_pc_write  = w_pc_write && !i_reset;
    assign o_mem_write = w_mem_write && !i_reset;
    assign o_ir_write  = w_ir_write && !i_reset;
    assign o_reg_write = w_reg_write && !i_reset;
    assign o_flags_reg = r_flags;

endmodule
